ct_ifu_icache_tag_ctrl: RTL and testbench

Requester-side controller for the 2-way icache tag SRAM wrapper. It owns the tag-array port and arbitrates three sources: invalidate-all sweep, refill tag write and lookup read. On a lookup it compares both ways, reports the hit vector, then writes back the LRU bit. It sits in the IFU between the fetch/refill logic and the tag array.

---
 rtl/ct_ifu_icache_tag_ctrl_if.sv | 41 ++++
 rtl/ct_ifu_icache_tag_ctrl.sv | 107 ++++++++++
 tb/tb_ct_ifu_icache_tag_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ct_ifu_icache_tag_ctrl_if.sv
// ct_ifu_icache_tag_ctrl_if: request/response and tag-array port bundle of the icache tag controller
interface ct_ifu_icache_tag_ctrl_if #(
  parameter int INDEX_W = 8,
  parameter int TAG_W = 28
);
  logic inv_all_req;
  logic inv_all_done;
  logic busy;
  logic refill_req;
  logic refill_ack;
  logic [INDEX_W-1:0] refill_index;
  logic refill_way;
  logic [TAG_W-1:0] refill_tag;
  logic lookup_req;
  logic lookup_gnt;
  logic [INDEX_W-1:0] lookup_index;
  logic [TAG_W-1:0] lookup_tag;
  logic lookup_vld;
  logic [1:0] lookup_hit;
  logic lookup_lru;
  logic [15:0] ifu_icache_index;
  logic ifu_icache_tag_cen_b;
  logic ifu_icache_tag_clk_en;
  logic [2*TAG_W+2:0] ifu_icache_tag_din;
  logic [2:0] ifu_icache_tag_wen;
  logic [2*TAG_W+2:0] icache_ifu_tag_dout;
  modport master (
    output inv_all_req, refill_req, refill_index, refill_way, refill_tag,
           lookup_req, lookup_index, lookup_tag, icache_ifu_tag_dout,
    input  inv_all_done, busy, refill_ack, lookup_gnt, lookup_vld, lookup_hit, lookup_lru,
           ifu_icache_index, ifu_icache_tag_cen_b, ifu_icache_tag_clk_en,
           ifu_icache_tag_din, ifu_icache_tag_wen
  );
  modport slave (
    input  inv_all_req, refill_req, refill_index, refill_way, refill_tag,
           lookup_req, lookup_index, lookup_tag, icache_ifu_tag_dout,
    output inv_all_done, busy, refill_ack, lookup_gnt, lookup_vld, lookup_hit, lookup_lru,
           ifu_icache_index, ifu_icache_tag_cen_b, ifu_icache_tag_clk_en,
           ifu_icache_tag_din, ifu_icache_tag_wen
  );
endinterface

// File: rtl/ct_ifu_icache_tag_ctrl.sv
// ct_ifu_icache_tag_ctrl: arbitrates invalidate sweep, refill write and lookup on the 2-way icache tag array
module ct_ifu_icache_tag_ctrl #(
  parameter int INDEX_W = 8,
  parameter int TAG_W = 28
) (
  input logic forever_cpuclk,
  input logic cpurst,
  ct_ifu_icache_tag_ctrl_if.slave bus
);
  localparam int WW = TAG_W + 1;
  localparam int DW = 2 * WW + 1;
  typedef enum logic [1:0] {IDLE, INV, RD, LRU_WR} state_t;
  state_t state, state_nxt;
  logic [INDEX_W-1:0] cnt, idx_q;
  logic [TAG_W-1:0] tag_q;
  logic hitway_q;
  logic [1:0] hit;
  logic hitway;
  logic last;
  logic [WW-1:0] refill_data;
  logic [DW-1:0] rd;
  function automatic logic [15:0] arr_index(input logic [INDEX_W-1:0] s);
    return 16'(s) << 5;
  endfunction
  assign rd = bus.icache_ifu_tag_dout;
  assign hit = {rd[2*WW-1] & (rd[WW +: TAG_W] == tag_q), rd[WW-1] & (rd[TAG_W-1:0] == tag_q)};
  assign hitway = ~hit[0];
  assign last = &cnt;
  assign refill_data = {1'b1, bus.refill_tag};
  assign bus.ifu_icache_tag_clk_en = ~bus.ifu_icache_tag_cen_b;
  // Next state and array-port drive; everything stays idle while reset is asserted
  always_comb begin
    state_nxt = state;
    bus.inv_all_done = 1'b0;
    bus.busy = 1'b0;
    bus.refill_ack = 1'b0;
    bus.lookup_gnt = 1'b0;
    bus.lookup_vld = 1'b0;
    bus.lookup_hit = 2'b00;
    bus.lookup_lru = 1'b0;
    bus.ifu_icache_index = 16'h0;
    bus.ifu_icache_tag_cen_b = 1'b1;
    bus.ifu_icache_tag_din = '0;
    bus.ifu_icache_tag_wen = 3'b111;
    if (!cpurst) begin
      case (state)
        IDLE: begin
          if (bus.inv_all_req) begin
            state_nxt = INV;
          end else if (bus.refill_req) begin
            bus.refill_ack = 1'b1;
            bus.ifu_icache_tag_cen_b = 1'b0;
            bus.ifu_icache_tag_wen = {1'b0, ~bus.refill_way, bus.refill_way};
            bus.ifu_icache_index = arr_index(bus.refill_index);
            bus.ifu_icache_tag_din = {~bus.refill_way, bus.refill_way ? refill_data : WW'(0),
                                      bus.refill_way ? WW'(0) : refill_data};
          end else if (bus.lookup_req) begin
            bus.lookup_gnt = 1'b1;
            bus.ifu_icache_tag_cen_b = 1'b0;
            bus.ifu_icache_index = arr_index(bus.lookup_index);
            state_nxt = RD;
          end
        end
        INV: begin
          bus.busy = 1'b1;
          bus.ifu_icache_tag_cen_b = 1'b0;
          bus.ifu_icache_tag_wen = 3'b000;
          bus.ifu_icache_index = arr_index(cnt);
          bus.inv_all_done = last;
          state_nxt = last ? IDLE : INV;
        end
        RD: begin
          bus.lookup_vld = 1'b1;
          bus.lookup_hit = hit;
          bus.lookup_lru = rd[DW-1];
          state_nxt = (|hit && rd[DW-1] != ~hitway) ? LRU_WR : IDLE;
        end
        LRU_WR: begin
          bus.ifu_icache_tag_cen_b = 1'b0;
          bus.ifu_icache_tag_wen = 3'b011;
          bus.ifu_icache_index = arr_index(idx_q);
          bus.ifu_icache_tag_din = {~hitway_q, {(DW-1){1'b0}}};
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end
  // State register and sweep counter; the counter parks at 0 outside the sweep
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= (state == INV && !last) ? cnt + 1'b1 : '0;
    end
  end
  // Lookup context; only consumed after a grant, so it needs no reset
  always_ff @(posedge forever_cpuclk) begin
    if (bus.lookup_gnt) begin
      idx_q <= bus.lookup_index;
      tag_q <= bus.lookup_tag;
    end
    if (state == RD) hitway_q <= hitway;
  end
endmodule

// File: tb/tb_ct_ifu_icache_tag_ctrl.sv
// tb_ct_ifu_icache_tag_ctrl: directed bench with a tag-store reference model and per-cycle output compare
module tb_ct_ifu_icache_tag_ctrl;
  localparam int IW = 8;
  localparam int TW = 28;
  localparam int NS = 1 << IW;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  logic [28:0] rw0 [NS];
  logic [28:0] rw1 [NS];
  logic rl [NS];
  logic [58:0] mem [NS];
  always #5 clk = ~clk;
  ct_ifu_icache_tag_ctrl_if #(.INDEX_W(IW), .TAG_W(TW)) bus ();
  ct_ifu_icache_tag_ctrl #(.INDEX_W(IW), .TAG_W(TW)) dut (
    .forever_cpuclk(clk),
    .cpurst(rst),
    .bus(bus)
  );
  // Tag SRAM: registered read, per-field active-low write enables
  always @(posedge clk) begin
    if (!bus.ifu_icache_tag_cen_b) begin
      if (bus.ifu_icache_tag_wen == 3'b111) bus.icache_ifu_tag_dout <= mem[bus.ifu_icache_index[12:5]];
      if (!bus.ifu_icache_tag_wen[0]) mem[bus.ifu_icache_index[12:5]][28:0] <= bus.ifu_icache_tag_din[28:0];
      if (!bus.ifu_icache_tag_wen[1]) mem[bus.ifu_icache_index[12:5]][57:29] <= bus.ifu_icache_tag_din[57:29];
      if (!bus.ifu_icache_tag_wen[2]) mem[bus.ifu_icache_index[12:5]][58] <= bus.ifu_icache_tag_din[58];
    end
  end
  function automatic logic [1:0] mhit(input int s, input logic [27:0] t);
    return {rw1[s][28] && rw1[s][27:0] == t, rw0[s][28] && rw0[s][27:0] == t};
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Reference model: tag store per set plus pending lookup / LRU update, checked every cycle
  initial begin
    logic sw, prd, plw, lval;
    int sc, pidx, lidx;
    logic [27:0] ptag;
    logic e_busy, e_done, e_ack, e_gnt, e_vld, e_lru, e_cen;
    logic [1:0] e_hit;
    logic [2:0] e_wen;
    logic [15:0] e_idx;
    logic [58:0] e_din;
    logic [87:0] a, e;
    sw = 0; prd = 0; plw = 0; lval = 0; sc = 0; pidx = 0; lidx = 0; ptag = 0;
    for (int i = 0; i < NS; i++) begin
      rw0[i] = 0;
      rw1[i] = 0;
      rl[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (rst) begin
        sw = 0; prd = 0; plw = 0;
      end else begin
        {e_busy, e_done, e_ack, e_gnt, e_vld, e_lru, e_hit} = '0;
        e_cen = 1; e_wen = 3'b111; e_idx = 0; e_din = 0;
        if (sw) begin
          e_busy = 1; e_cen = 0; e_wen = 3'b000; e_idx = 16'(sc * 32); e_done = (sc == NS - 1);
        end else if (prd) begin
          e_vld = 1; e_hit = mhit(pidx, ptag); e_lru = rl[pidx];
        end else if (plw) begin
          e_cen = 0; e_wen = 3'b011; e_idx = 16'(lidx * 32); e_din = 59'(lval) << 58;
        end else if (bus.inv_all_req) begin
        end else if (bus.refill_req) begin
          e_ack = 1; e_cen = 0;
          e_wen = bus.refill_way ? 3'b001 : 3'b010;
          e_idx = 16'(int'(bus.refill_index) * 32);
          e_din = (59'(!bus.refill_way) << 58) | (59'({1'b1, bus.refill_tag}) << (29 * int'(bus.refill_way)));
        end else if (bus.lookup_req) begin
          e_gnt = 1; e_cen = 0; e_idx = 16'(int'(bus.lookup_index) * 32);
        end
        a = {bus.busy, bus.inv_all_done, bus.refill_ack, bus.lookup_gnt, bus.lookup_vld, bus.lookup_hit,
             bus.lookup_lru, bus.ifu_icache_tag_cen_b, bus.ifu_icache_tag_clk_en, bus.ifu_icache_tag_wen,
             bus.ifu_icache_index, bus.ifu_icache_tag_din};
        e = {e_busy, e_done, e_ack, e_gnt, e_vld, e_hit, e_lru, e_cen, !e_cen, e_wen, e_idx, e_din};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL cycle t=%0t: got %h expected %h", $time, a, e);
        end
        if (sw) begin
          rw0[sc] = 0; rw1[sc] = 0; rl[sc] = 0;
          if (sc == NS - 1) sw = 0;
          else sc++;
        end else if (prd) begin
          prd = 0;
          lval = e_hit[0] ? 1'b1 : 1'b0;
          lidx = pidx;
          plw = |e_hit && rl[pidx] != lval;
        end else if (plw) begin
          rl[lidx] = lval;
          plw = 0;
        end else if (bus.inv_all_req) begin
          sw = 1; sc = 0;
        end else if (bus.refill_req) begin
          if (bus.refill_way) rw1[bus.refill_index] = {1'b1, bus.refill_tag};
          else rw0[bus.refill_index] = {1'b1, bus.refill_tag};
          rl[bus.refill_index] = !bus.refill_way;
        end else if (bus.lookup_req) begin
          prd = 1; pidx = int'(bus.lookup_index); ptag = bus.lookup_tag;
        end
      end
    end
  end
  task automatic sweep;
    int nb, nd;
    logic [15:0] didx;
    nb = 0; nd = 0; didx = 0;
    bus.inv_all_req = 1;
    tick;
    bus.inv_all_req = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.busy) nb++;
      if (bus.inv_all_done) begin
        nd++;
        didx = bus.ifu_icache_index;
        break;
      end
    end
    chk("sweep_writes", 64'(nb), 64'(256));
    chk("sweep_done", 64'({nd[7:0], didx}), 64'({8'd1, 16'h1FE0}));
    @(negedge clk);
    chk("sweep_busy_off", 64'(bus.busy), 64'(0));
    tick;
  endtask
  task automatic refill(input int s, input logic w, input logic [27:0] t, input logic [2:0] ew, input logic el);
    bus.refill_index = 8'(s); bus.refill_way = w; bus.refill_tag = t; bus.refill_req = 1;
    @(negedge clk);
    chk("refill_ack", 64'({bus.refill_ack, bus.ifu_icache_tag_wen, bus.ifu_icache_index}), 64'({1'b1, ew, 16'(s * 32)}));
    chk("refill_data", 64'({bus.ifu_icache_tag_din[58], w ? bus.ifu_icache_tag_din[57:29] : bus.ifu_icache_tag_din[28:0]}),
        64'({el, 1'b1, t}));
    tick;
    bus.refill_req = 0;
  endtask
  task automatic lookup(input int s, input logic [27:0] t, input logic [1:0] eh, input logic el, input logic ew, input logic eb);
    bus.lookup_index = 8'(s); bus.lookup_tag = t; bus.lookup_req = 1;
    @(negedge clk);
    chk("lookup_gnt", 64'(bus.lookup_gnt), 64'(1));
    tick;
    bus.lookup_req = 0;
    @(negedge clk);
    chk("lookup_result", 64'({bus.lookup_vld, bus.lookup_hit, bus.lookup_lru}), 64'({1'b1, eh, el}));
    tick;
    @(negedge clk);
    chk("lru_write", 64'({bus.ifu_icache_tag_cen_b, bus.ifu_icache_tag_wen}), ew ? 64'(4'b0011) : 64'(4'b1111));
    if (ew) chk("lru_write_data", 64'({bus.ifu_icache_tag_din[58], bus.ifu_icache_index}), 64'({eb, 16'(s * 32)}));
    tick;
  endtask
  initial begin
    int bad, nd;
    logic found;
    bus.inv_all_req = 0; bus.refill_req = 0; bus.refill_index = 0; bus.refill_way = 0; bus.refill_tag = 0;
    bus.lookup_req = 0; bus.lookup_index = 0; bus.lookup_tag = 0; bus.icache_ifu_tag_dout = 0;
    rst = 1;
    repeat (2) tick;
    rst = 0;
    @(negedge clk);
    chk("reset_idle", 64'({bus.busy, bus.ifu_icache_tag_cen_b, bus.ifu_icache_tag_clk_en, bus.ifu_icache_tag_wen, bus.ifu_icache_index}),
        64'({1'b0, 1'b1, 1'b0, 3'b111, 16'h0}));
    tick;
    sweep();
    refill(5, 1'b1, 28'hABCDEF1, 3'b001, 1'b0);
    lookup(5, 28'hABCDEF1, 2'b10, 1'b0, 1'b0, 1'b0);
    refill(5, 1'b0, 28'h1111111, 3'b010, 1'b1);
    lookup(5, 28'hABCDEF1, 2'b10, 1'b1, 1'b1, 1'b0);
    lookup(5, 28'hABCDEF1, 2'b10, 1'b0, 1'b0, 1'b0);
    lookup(5, 28'h1111111, 2'b01, 1'b0, 1'b1, 1'b1);
    lookup(7, 28'h1234567, 2'b00, 1'b0, 1'b0, 1'b0);
    refill(9, 1'b0, 28'h2222222, 3'b010, 1'b1);
    refill(9, 1'b1, 28'h2222222, 3'b001, 1'b0);
    lookup(9, 28'h2222222, 2'b11, 1'b0, 1'b1, 1'b1);
    bus.refill_index = 8'd3; bus.refill_way = 1; bus.refill_tag = 28'h3333333; bus.refill_req = 1;
    bus.lookup_index = 8'd3; bus.lookup_tag = 28'h3333333; bus.lookup_req = 1;
    @(negedge clk);
    chk("arb_refill_first", 64'({bus.refill_ack, bus.lookup_gnt}), 64'(2'b10));
    tick;
    bus.refill_req = 0;
    @(negedge clk);
    chk("arb_lookup_next", 64'({bus.refill_ack, bus.lookup_gnt}), 64'(2'b01));
    tick;
    bus.lookup_req = 0;
    @(negedge clk);
    chk("arb_lookup_result", 64'({bus.lookup_vld, bus.lookup_hit, bus.lookup_lru}), 64'(4'b1100));
    tick;
    bus.inv_all_req = 1;
    tick;
    bus.inv_all_req = 0;
    bus.refill_index = 8'd4; bus.refill_way = 0; bus.refill_tag = 28'h4444444; bus.refill_req = 1;
    bus.lookup_index = 8'd4; bus.lookup_tag = 28'h4444444; bus.lookup_req = 1;
    bad = 0; nd = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.refill_ack || bus.lookup_gnt) bad++;
      if (bus.inv_all_done) begin
        nd++;
        break;
      end
    end
    chk("inv_holds_requests", 64'({bad[15:0], nd[15:0]}), 64'({16'd0, 16'd1}));
    @(negedge clk);
    chk("post_inv_refill", 64'({bus.refill_ack, bus.lookup_gnt}), 64'(2'b10));
    tick;
    bus.refill_req = 0;
    @(negedge clk);
    chk("post_inv_lookup", 64'({bus.refill_ack, bus.lookup_gnt}), 64'(2'b01));
    tick;
    bus.lookup_req = 0;
    @(negedge clk);
    chk("post_inv_result", 64'({bus.lookup_vld, bus.lookup_hit, bus.lookup_lru}), 64'(4'b1011));
    tick;
    @(negedge clk);
    chk("post_inv_no_write", 64'(bus.ifu_icache_tag_cen_b), 64'(1));
    tick;
    bus.inv_all_req = 1;
    tick;
    bus.inv_all_req = 0;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (bus.busy && bus.ifu_icache_index == 16'(99 * 32)) found = 1;
    end
    chk("reach_set_99", 64'(found), 64'(1));
    tick;
    rst = 1;
    tick;
    rst = 0;
    @(negedge clk);
    chk("reset_abort", 64'({bus.ifu_icache_tag_cen_b, bus.busy, bus.inv_all_done}), 64'(3'b100));
    nd = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.inv_all_done || bus.busy) nd++;
    end
    chk("no_done_after_reset", 64'(nd), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
